fetch_unit: RTL
===============

Name: fetch_unit

Overview:
- Instruction-fetch side of the program counter interface.
- Consumes the current PC, runs a variable-latency req/ack transaction to instruction memory, and loads the fetched word into the IF/ID register.
- Drives the PC register's stall input so the PC advances exactly once per instruction delivered to decode, or once on a redirect.
- Handles decode back-pressure (id_stall) and branch redirects (flush).

Parameters:
ADDR_W, 32, PC / instruction-memory address width
DATA_W, 32, instruction word width
NOP, 32'h00000000, value of instr_out when no valid instruction is held

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pc  input  ADDR_W  current PC from the PC register
stall_out  output  1  to the PC register's stall input; 0 = PC loads its next value this edge
imem_req  output  1  memory request, registered
imem_addr  output  ADDR_W  request address, registered, stable while imem_req=1
imem_ack  input  1  memory completion strobe, one cycle, valid only while imem_req=1
imem_rdata  input  DATA_W  instruction word, valid when imem_ack=1
id_stall  input  1  decode stall; IF/ID contents must hold
flush  input  1  taken-branch redirect; discard current/in-flight instruction
instr_out  output  DATA_W  IF/ID instruction
instr_pc  output  ADDR_W  address of instr_out
instr_valid  output  1  instr_out is a real instruction

Behaviour:
- Reset (asynchronous, takes effect immediately, also mid-transaction) sets:
  - state=IDLE, imem_req=0, imem_addr=0, instr_out=NOP, instr_pc=0, instr_valid=0, flush_pending=0, hold buffer cleared.
  - Memory must tolerate an abandoned request.
- States: IDLE, WAIT, HOLD.
- Internal signals:
  - deliver = (WAIT & imem_ack & !flush_pending & !flush & !id_stall) | (HOLD & !id_stall & !flush).
  - stall_out = !(deliver | flush), combinational.
- IDLE:
  - If !flush: imem_req<=1, imem_addr<=pc, go WAIT.
  - If flush: stay IDLE with no request; the PC loads the redirect target this edge and the next cycle issues it.
- WAIT:
  - imem_req and imem_addr hold until imem_ack=1.
  - flush without ack: flush_pending<=1, stay WAIT. The transaction is never abandoned; only the PC moves.
  - ack with flush or flush_pending: data discarded, imem_req<=0, flush_pending<=0, go IDLE.
  - ack with deliver: instr_out<=imem_rdata, instr_pc<=imem_addr, instr_valid<=1, imem_req<=0, go IDLE.
  - ack with id_stall=1 (no flush): imem_rdata and imem_addr are captured into the hold buffer, imem_req<=0, go HOLD.
- HOLD:
  - id_stall=0 and no flush: buffer moves to IF/ID, instr_valid<=1, go IDLE.
  - flush: buffer discarded, go IDLE.
  - Otherwise stay HOLD.
- IF/ID register rules:
  - flush: instr_valid<=0, instr_out<=NOP (flush overrides id_stall).
  - Else id_stall=1: all IF/ID outputs hold.
  - Else no deliver: instr_valid<=0, instr_out<=NOP.
- Latency: with single-cycle ack and no stalls, one instruction per 2 cycles (issue, ack/deliver). The PC advances on the deliver edge.
- At most one outstanding memory request at any time.
- pc is sampled only in IDLE.

Test Plan:
- Reset, pc=0, memory returning 32'h20080005 with ack one cycle after req -> imem_req rises at edge 1 with imem_addr=0; at edge 2 instr_out=32'h20080005, instr_pc=0, instr_valid=1; stall_out=0 only in the ack cycle.
- 3-cycle ack latency -> imem_req and imem_addr stable for 3 cycles, stall_out=1 throughout, PC held at 0x4 until ack.
- id_stall=1 when ack arrives for pc=0x8 -> state HOLD, instr_out unchanged, stall_out=1; id_stall drops 2 cycles later -> instr_pc=0x8, instr_valid=1, stall_out=0 for exactly 1 cycle.
- flush in WAIT two cycles before ack -> stall_out=0 in the flush cycle, instr_valid=0; at ack the data is discarded; the next imem_addr equals the redirected pc (e.g. 0x40).
- flush and ack in the same cycle, and flush while in HOLD -> no instr_valid pulse; the next request uses the new pc.
- reset asserted mid-WAIT -> imem_req=0 and instr_valid=0 immediately, without waiting for a clock; after release the first request is at imem_addr=pc=0.

Source files
------------

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request/ack bus between fetch unit and memory
interface fetch_unit_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) ();
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [DATA_W-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - PC-driven instruction fetch with variable-latency memory and IF/ID register
module fetch_unit #(
    parameter int              ADDR_W = 32,
    parameter int              DATA_W = 32,
    parameter logic [DATA_W-1:0] NOP  = 32'h00000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] pc,
    output logic              stall_out,
    fetch_unit_if.master      imem,
    input  logic              id_stall,
    input  logic              flush,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid
);
    typedef enum logic [1:0] {IDLE, WAIT, HOLD} state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              flush_pending_q, flush_pending_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] out_q, out_d;
    logic [ADDR_W-1:0] opc_q, opc_d;
    logic              valid_q, valid_d;
    logic              deliver;

    always_comb begin
        deliver = ((state_q == WAIT) && imem.imem_ack && !flush_pending_q && !flush && !id_stall)
               || ((state_q == HOLD) && !id_stall && !flush);
        stall_out = !(deliver || flush);
    end

    always_comb begin
        state_d         = state_q;
        req_d           = req_q;
        addr_d          = addr_q;
        flush_pending_d = flush_pending_q;
        hold_data_d     = hold_data_q;
        hold_addr_d     = hold_addr_q;
        out_d           = out_q;
        opc_d           = opc_q;
        valid_d         = valid_q;

        case (state_q)
            IDLE: begin
                if (!flush) begin
                    req_d   = 1'b1;
                    addr_d  = pc;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // The request always runs to completion; a redirect only marks its data stale.
                if (imem.imem_ack) begin
                    req_d           = 1'b0;
                    flush_pending_d = 1'b0;
                    state_d         = IDLE;
                    if (!flush && !flush_pending_q && id_stall) begin
                        hold_data_d = imem.imem_rdata;
                        hold_addr_d = addr_q;
                        state_d     = HOLD;
                    end
                end else if (flush) begin
                    flush_pending_d = 1'b1;
                end
            end
            HOLD: begin
                if (flush || !id_stall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (flush) begin
            valid_d = 1'b0;
            out_d   = NOP;
        end else if (!id_stall) begin
            if (deliver) begin
                valid_d = 1'b1;
                if (state_q == HOLD) begin
                    out_d = hold_data_q;
                    opc_d = hold_addr_q;
                end else begin
                    out_d = imem.imem_rdata;
                    opc_d = addr_q;
                end
            end else begin
                valid_d = 1'b0;
                out_d   = NOP;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= IDLE;
            req_q           <= 1'b0;
            addr_q          <= '0;
            flush_pending_q <= 1'b0;
            hold_data_q     <= '0;
            hold_addr_q     <= '0;
            out_q           <= NOP;
            opc_q           <= '0;
            valid_q         <= 1'b0;
        end else begin
            state_q         <= state_d;
            req_q           <= req_d;
            addr_q          <= addr_d;
            flush_pending_q <= flush_pending_d;
            hold_data_q     <= hold_data_d;
            hold_addr_q     <= hold_addr_d;
            out_q           <= out_d;
            opc_q           <= opc_d;
            valid_q         <= valid_d;
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr_out      = out_q;
    assign instr_pc       = opc_q;
    assign instr_valid    = valid_q;
endmodule
